// File: rtl/video_mode_sequencer.sv
// -----------------------------------------------------------------------------
// video_mode_sequencer
//
// Accepts a raw mode code from the control MCU and filters it for stability.
// Maps the code onto one of NUM_MODES mode indices, then defers the switch to
// the next frame boundary. It handshakes with the pixel-clock reconfiguration
// logic before the new index becomes active.
//
// Optional feature: define VIDEO_MODE_SEQ_TIMEOUT_EN to abandon a
// reconfiguration after TIMEOUT_CYCLES without an ack. This sets the sticky
// reconfig_timeout flag. Without the macro, RECONF waits indefinitely and
// reconfig_timeout is constant 0.
//
// Ports:
//   clock            in   system clock
//   reset            in   synchronous, active-high reset
//   data_in          in   raw mode code from MCU (DATA_W)
//   frame_start      in   single-cycle pulse at first pixel of a frame
//   reconfig_ack     in   reconfig logic done (sampled in RECONF only)
//   mode_index       out  currently active mode index (IDX_W)
//   target_index     out  mode index being requested (IDX_W)
//   reconfig_req     out  high while in RECONF
//   mode_changed     out  one-cycle pulse when mode_index updates
//   busy             out  high in PENDING or RECONF
//   reconfig_timeout out  sticky reconfiguration timeout flag
// -----------------------------------------------------------------------------
module video_mode_sequencer #(
   parameter int                          DATA_W         = 8,
   parameter int                          NUM_MODES      = 5,
   parameter int                          IDX_W          = 3,
   parameter logic [NUM_MODES*DATA_W-1:0] MODE_CODES     = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
   parameter int                          DEFAULT_MODE   = 0,
   parameter int                          STABLE_CYCLES  = 4,
   parameter int                          TIMEOUT_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              frame_start,
   input  logic              reconfig_ack,
   output logic [IDX_W-1:0]  mode_index,
   output logic [IDX_W-1:0]  target_index,
   output logic              reconfig_req,
   output logic              mode_changed,
   output logic              busy,
   output logic              reconfig_timeout
);

   localparam int                CNT_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [IDX_W-1:0]  DEF_IDX    = IDX_W'(DEFAULT_MODE);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_RECONF
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_reg_q, data_reg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    mode_q, mode_d;
   logic [IDX_W-1:0]    target_q, target_d;
   logic                chg_q, chg_d;

   logic                stable;
   logic                lut_valid;
   logic [IDX_W-1:0]    lut_idx;
   logic                code_ok;
   logic                timeout_hit;

   // Code table lookup; scanning downwards lets the lowest matching index win.
   always_comb begin
      lut_valid = 1'b0;
      lut_idx   = '0;
      for (int i = NUM_MODES - 1; i >= 0; i--) begin
         if (data_reg_q == MODE_CODES[i*DATA_W +: DATA_W]) begin
            lut_valid = 1'b1;
            lut_idx   = IDX_W'(i);
         end
      end
   end

   assign stable  = (cnt_q == STABLE_MAX);
   assign code_ok = stable && lut_valid;

   always_comb begin
      data_reg_d = data_in;
      if (data_in != data_reg_q) begin
         cnt_d = '0;
      end else if (cnt_q != STABLE_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end

      state_d  = state_q;
      mode_d   = mode_q;
      target_d = target_q;
      chg_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (code_ok && (lut_idx != mode_q)) begin
               target_d = lut_idx;
               state_d  = ST_PENDING;
            end
         end
         ST_PENDING: begin
            // A cancel overrides a coincident frame_start. A retarget is
            // folded into target before the frame boundary is acted on.
            if (code_ok && (lut_idx == mode_q)) begin
               target_d = mode_q;
               state_d  = ST_IDLE;
            end else begin
               if (code_ok) begin
                  target_d = lut_idx;
               end
               if (frame_start) begin
                  state_d = ST_RECONF;
               end
            end
         end
         ST_RECONF: begin
            if (reconfig_ack) begin
               mode_d  = target_q;
               chg_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (timeout_hit) begin
               target_d = mode_q;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         data_reg_q <= '0;
         cnt_q      <= '0;
         mode_q     <= DEF_IDX;
         target_q   <= DEF_IDX;
         chg_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_reg_q <= data_reg_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         target_q   <= target_d;
         chg_q      <= chg_d;
      end
   end

`ifdef VIDEO_MODE_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            to_flag_q, to_flag_d;

   // Counter restarts on every entry to RECONF. The last permitted cycle is
   // TIMEOUT_CYCLES-1, and an ack in that cycle still wins.
   always_comb begin
      to_cnt_d    = (state_q == ST_RECONF) ? (to_cnt_q + TO_W'(1)) : '0;
      timeout_hit = (state_q == ST_RECONF) && !reconfig_ack &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
      to_flag_d   = to_flag_q | timeout_hit;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         to_cnt_q  <= '0;
         to_flag_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_d;
      end
   end

   assign reconfig_timeout = to_flag_q;
`else
   assign timeout_hit      = 1'b0;
   // Constant 0; TIMEOUT_CYCLES only matters when the timeout is built in.
   assign reconfig_timeout = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

   assign mode_index   = mode_q;
   assign target_index = target_q;
   assign reconfig_req = (state_q == ST_RECONF);
   assign busy         = (state_q != ST_IDLE);
   assign mode_changed = chg_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_video_mode_sequencer
//
// Self-checking bench for video_mode_sequencer. A driver issues directed and
// random stimulus and pushes the expected post-edge outputs into a queue. A
// separate monitor pops and compares them after every clock edge. Completed
// mode switches go into their own queue, which is consumed on each
// mode_changed pulse.
// -----------------------------------------------------------------------------
module tb_video_mode_sequencer;

   localparam int DATA_W    = 8;
   localparam int NUM_MODES = 5;
   localparam int IDX_W     = 3;
   localparam int STABLE    = 4;
   localparam int TIMEOUT   = 16;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [DATA_W-1:0] data_in = '0;
   logic              frame_start = 1'b0;
   logic              reconfig_ack = 1'b0;
   logic [IDX_W-1:0]  mode_index;
   logic [IDX_W-1:0]  target_index;
   logic              reconfig_req;
   logic              mode_changed;
   logic              busy;
   logic              reconfig_timeout;

   video_mode_sequencer #(
      .DATA_W         (DATA_W),
      .NUM_MODES      (NUM_MODES),
      .IDX_W          (IDX_W),
      .MODE_CODES     ({8'h05, 8'h04, 8'h03, 8'h02, 8'h01}),
      .DEFAULT_MODE   (0),
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .data_in          (data_in),
      .frame_start      (frame_start),
      .reconfig_ack     (reconfig_ack),
      .mode_index       (mode_index),
      .target_index     (target_index),
      .reconfig_req     (reconfig_req),
      .mode_changed     (mode_changed),
      .busy             (busy),
      .reconfig_timeout (reconfig_timeout)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [IDX_W-1:0] mode;
      logic [IDX_W-1:0] target;
      logic             req;
      logic             bsy;
      logic             chg;
      logic             tmo;
   } exp_t;

   exp_t             exp_q[$];
   logic [IDX_W-1:0] chg_exp_q[$];

   int tests = 0;
   int fails = 0;

   // Reference model: phase 0 = idle, 1 = waiting for frame, 2 = reconfiguring.
   int               m_phase = 0;
   logic [IDX_W-1:0] m_mode = '0;
   logic [IDX_W-1:0] m_target = '0;
   bit               m_chg = 0;
   bit               m_to = 0;
   int               m_tocnt = 0;
   logic [7:0]       hist[$];
   logic [7:0]       codes[NUM_MODES] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // A code counts as stable once the last STABLE+1 samples are identical;
   // the register's reset value of 0 is the first sample after reset.
   task automatic model_step(input bit r, input logic [7:0] d, input bit f, input bit a);
      bit               stable;
      bit               ok;
      logic [IDX_W-1:0] idx;
      if (r) begin
         m_phase = 0; m_mode = '0; m_target = '0; m_chg = 0; m_to = 0; m_tocnt = 0;
         hist.delete();
         hist.push_back(8'h00);
      end else begin
         stable = (hist.size() == STABLE + 1);
         foreach (hist[i]) if (hist[i] != hist[0]) stable = 0;
         ok = 0; idx = '0;
         for (int i = 0; i < NUM_MODES; i++) begin
            if (!ok && hist[$] == codes[i]) begin
               ok = 1; idx = IDX_W'(i);
            end
         end
         ok = ok && stable;
         m_chg = 0;
         if (m_phase == 0) begin
            if (ok && idx != m_mode) begin
               m_target = idx; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (ok && idx == m_mode) begin
               m_target = m_mode; m_phase = 0;
            end else begin
               if (ok) m_target = idx;
               if (f) begin
                  m_phase = 2; m_tocnt = 0;
               end
            end
         end else begin
            if (a) begin
               m_mode = m_target; m_chg = 1; m_phase = 0;
               chg_exp_q.push_back(m_mode);
            end
`ifdef VIDEO_MODE_SEQ_TIMEOUT_EN
            else if (m_tocnt == TIMEOUT - 1) begin
               m_target = m_mode; m_phase = 0; m_to = 1;
            end else begin
               m_tocnt++;
            end
`endif
         end
         hist.push_back(d);
         if (hist.size() > STABLE + 1) void'(hist.pop_front());
      end
   endtask

   task automatic cycle(input bit r, input logic [7:0] d, input bit f, input bit a);
      exp_t e;
      @(negedge clock);
      reset = r; data_in = d; frame_start = f; reconfig_ack = a;
      model_step(r, d, f, a);
      e.mode = m_mode; e.target = m_target; e.req = (m_phase == 2);
      e.bsy = (m_phase != 0); e.chg = m_chg; e.tmo = m_to;
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic [7:0] d, input int n);
      repeat (n) cycle(0, d, 0, 0);
   endtask

   task automatic settle();
      @(posedge clock);
      #2;
   endtask

   // Monitor: compares the outputs of each edge against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mode_index", mode_index, e.mode);
            check("target_index", target_index, e.target);
            check("reconfig_req", reconfig_req, e.req);
            check("busy", busy, e.bsy);
            check("mode_changed", mode_changed, e.chg);
            check("reconfig_timeout", reconfig_timeout, e.tmo);
            if (mode_changed === 1'b1) begin
               if (chg_exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL chg_event: unexpected pulse, mode_index %0h, none queued", mode_index);
               end else begin
                  check("chg_mode", mode_index, chg_exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] pool[7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h7F, 8'h00};
      logic [7:0] rd;
      int         rn;

      // Reset, then code 03 -> PENDING with target 2; switch on frame + ack.
      repeat (3) cycle(1, 8'h03, 0, 0);
      settle();
      check("rst_mode", mode_index, 0);
      check("rst_busy", busy, 0);
      hold(8'h03, 12);
      settle();
      check("t1_mode_held", mode_index, 0);
      check("t1_busy", busy, 1);
      check("t1_target", target_index, 2);
      cycle(0, 8'h03, 1, 0);
      settle();
      check("t1_req", reconfig_req, 1);
      hold(8'h03, 3);
      cycle(0, 8'h03, 0, 1);
      settle();
      check("t1_mode_new", mode_index, 2);
      check("t1_pulse", mode_changed, 1);
      hold(8'h03, 1);
      settle();
      check("t1_pulse_end", mode_changed, 0);

      // Code toggling faster than the filter never leaves IDLE.
      for (int i = 0; i < 10; i++) begin
         hold(8'h02, 2);
         hold(8'h04, 2);
      end
      settle();
      check("t2_busy", busy, 0);
      check("t2_mode", mode_index, 2);

      // Unmapped code is ignored.
      repeat (2) cycle(1, 8'h7F, 0, 0);
      hold(8'h7F, 20);
      settle();
      check("t3_mode", mode_index, 0);
      check("t3_busy", busy, 0);

      // Retarget within PENDING, then cancel back to the active mode.
      hold(8'h04, 10);
      settle();
      check("t4_target3", target_index, 3);
      hold(8'h05, 10);
      settle();
      check("t4_target4", target_index, 4);
      check("t4_busy", busy, 1);
      hold(8'h01, 10);
      settle();
      check("t4_cancel_busy", busy, 0);
      check("t4_cancel_target", target_index, 0);

      // Inputs ignored while in RECONF; a fresh sequence follows the ack.
      hold(8'h04, 10);
      cycle(0, 8'h04, 1, 0);
      settle();
      check("t5_req", reconfig_req, 1);
      repeat (10) cycle(0, 8'h02, 1, 0);
      settle();
      check("t5_still_req", reconfig_req, 1);
      check("t5_target", target_index, 3);
      cycle(0, 8'h02, 0, 1);
      settle();
      check("t5_mode", mode_index, 3);
      hold(8'h02, 1);
      settle();
      check("t5_new_busy", busy, 1);
      check("t5_new_target", target_index, 1);

`ifdef VIDEO_MODE_SEQ_TIMEOUT_EN
      // Withheld ack: back to IDLE after TIMEOUT cycles in RECONF.
      cycle(0, 8'h02, 1, 0);
      hold(8'h02, TIMEOUT - 1);
      settle();
      check("t6_req_before", reconfig_req, 1);
      hold(8'h02, 1);
      settle();
      check("t6_req_after", reconfig_req, 0);
      check("t6_flag", reconfig_timeout, 1);
      check("t6_mode", mode_index, 3);
`endif

      // Random phase.
      for (int n = 0; n < 600; n++) begin
         rd = pool[$urandom_range(0, 6)];
         rn = $urandom_range(1, 8);
         for (int k = 0; k < rn; k++) begin
            cycle(($urandom_range(0, 199) == 0), rd,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0));
         end
      end

      hold(8'h00, 4);
      repeat (3) @(posedge clock);
      #3;
      check("exp_drain", exp_q.size(), 0);
      check("chg_drain", chg_exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/video_mode_sequencer.md
Name: video_mode_sequencer

Overview:
- Successor to the single-register mode latch. Accepts a mode code from the control MCU and filters it for stability.
- Maps the code onto one of NUM_MODES parametrised mode indices. Defers the switch to the next frame boundary.
- Handshakes with the pixel-clock reconfiguration logic before the new mode index becomes active.
- Sits between the MCU register interface and the video timing generator / PLL reconfig block.

Parameters:
DATA_W, 8, width of incoming mode code
NUM_MODES, 5, number of supported video modes
IDX_W, 3, width of mode index (>= clog2(NUM_MODES))
MODE_CODES, {8'h05,8'h04,8'h03,8'h02,8'h01}, packed NUM_MODES*DATA_W code table; entry i at bits [i*DATA_W +: DATA_W]
DEFAULT_MODE, 0, index active after reset
STABLE_CYCLES, 4, consecutive unchanged cycles before a code is accepted (>=1)
TIMEOUT_CYCLES, 1024, reconfig ack timeout (optional feature only)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
data_in  in  DATA_W  raw mode code from MCU
frame_start  in  1  single-cycle pulse at first pixel of a frame
reconfig_ack  in  1  reconfig logic done (level or pulse; sampled in RECONF only)
mode_index  out  IDX_W  currently active mode index
target_index  out  IDX_W  mode index being requested
reconfig_req  out  1  high while in RECONF
mode_changed  out  1  one-cycle pulse when mode_index updates
busy  out  1  high in PENDING or RECONF
reconfig_timeout  out  1  sticky error flag (optional feature; 0 otherwise)

Behaviour:
Interface:
- One clock (clock).
- Reset (reset) is synchronous and active-high.

Reset values:
- mode_index = target_index = DEFAULT_MODE.
- reconfig_req = mode_changed = busy = reconfig_timeout = 0.
- State IDLE; stability counter 0; data_in_reg = 0.

Stability filter:
- data_in_reg <= data_in every cycle.
- Counter clears to 0 when data_in != data_in_reg. Otherwise it increments, saturating at STABLE_CYCLES.
- stable = (count == STABLE_CYCLES).

Lookup:
- Combinational match of data_in_reg against MODE_CODES. The lowest matching index wins.
- No match = code invalid. Invalid codes never cause a transition; the current mode is held.

States:
- IDLE:
  - Stable, valid and index != mode_index -> target_index <= index; go to PENDING next cycle.
- PENDING:
  - Stable, valid, index != mode_index and != target_index -> retarget (target_index updates, stay PENDING).
  - Stable, valid and index == mode_index -> cancel: back to IDLE, target_index <= mode_index.
  - frame_start -> RECONF. Evaluated after retarget/cancel; if both occur in the same cycle, cancel wins and retarget is applied before entering RECONF.
- RECONF:
  - reconfig_req = 1. data_in is ignored.
  - reconfig_ack -> mode_index <= target_index; mode_changed pulses 1 cycle; go to IDLE.
  - After returning to IDLE, a still-stable differing code starts a new sequence.

Other rules:
- Latency from a code change to entering PENDING: STABLE_CYCLES+2 cycles.
- frame_start in IDLE or RECONF is ignored.
- reconfig_ack outside RECONF is ignored.
- Reset mid-operation aborts any sequence and restores DEFAULT_MODE; no mode_changed pulse.
- busy = (state != IDLE).

Optional Feature:
Macro VIDEO_MODE_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in RECONF.
  - If TIMEOUT_CYCLES elapse without reconfig_ack: go to IDLE with mode_index unchanged, target_index <= mode_index, no mode_changed pulse, reconfig_timeout set.
  - reconfig_timeout is sticky until reset.
- Undefined:
  - RECONF waits indefinitely.
  - reconfig_timeout tied to 0; no counter logic is synthesised.

Test Plan:
- Reset, then hold data_in=8'h03 -> mode_index=0 until frame_start. Then reconfig_req=1, target_index=2. On ack: mode_index=2, one mode_changed pulse.
- data_in toggles 8'h02/8'h04 every 2 cycles (STABLE_CYCLES=4) -> never leaves IDLE; busy stays 0.
- data_in=8'h7F (unmapped), held 20 cycles -> no state change; mode_index stays 0.
- In PENDING (target 3 from 8'h04), set data_in=8'h05 stable before frame_start -> target_index=4. Then data_in=8'h01 -> cancel to IDLE, target_index=0.
- In RECONF, change data_in to 8'h02 and pulse frame_start -> ignored. After ack, the new sequence to index 1 starts.
- With VIDEO_MODE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold ack -> after 16 cycles in RECONF: IDLE, reconfig_timeout=1, mode_index unchanged.
